// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared types and constants for the tug-of-war automated player
// Contents:
//   ap_state_t          player FSM state encoding
//   CUE_PATTERN_DEFAULT Led value treated as the round-start cue
//   LFSR_TAPS           feedback tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
package tow_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        QUAL    = 3'd2,
        WAIT    = 3'd3,
        PRESS   = 3'd4,
        RELEASE = 3'd5,
        MASH    = 3'd6
    } ap_state_t;

    localparam logic [6:0] CUE_PATTERN_DEFAULT = 7'b1111111;
    localparam logic [7:0] LFSR_TAPS           = 8'hB8;

endpackage

// File: rtl/auto_player_lfsr.sv
// rtl/auto_player_lfsr.sv - 8-bit Fibonacci LFSR used as the reaction-time jitter source
// Ports:
//   clk  in   game clock
//   rst  in   synchronous active-low reset, loads SEED
//   q    out  current LFSR state, advances every cycle out of reset
module auto_player_lfsr
    import tow_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/auto_player.sv
// rtl/auto_player.sv - automated tug-of-war opponent reacting to the Led cue
// Ports:
//   clk          in   game clock (500 Hz)
//   rst          in   synchronous active-low reset
//   enable       in   player active; low returns to IDLE next cycle
//   side         in   0 = drive pbl, 1 = drive pbr (latched on IDLE->ARM)
//   mash         in   request repeated pressing
//   Led          in   game LED output being watched
//   pbl, pbr     out  button press outputs
//   busy         out  high in every state except IDLE and ARM
//   press_count  out  presses issued, saturating at 255
//   fake_count   out  cues rejected as too short, saturating at 15
module auto_player
    import tow_pkg::*;
#(
    parameter logic [6:0] CUE_PATTERN  = CUE_PATTERN_DEFAULT,
    parameter int         CUE_MIN      = 4,
    parameter int         REACT_BASE   = 100,
    parameter logic [5:0] JITTER_MASK  = 6'h3F,
    parameter int         PRESS_CYCLES = 25,
    parameter int         MASH_PERIOD  = 40,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       side,
    input  logic       mash,
    input  logic [6:0] Led,
    output logic       pbl,
    output logic       pbr,
    output logic       busy,
    output logic [7:0] press_count,
    output logic [3:0] fake_count
);

    localparam int QW = $clog2(CUE_MIN + 1);
    localparam int RW = $clog2(REACT_BASE + 64);
    localparam int PW = $clog2(MASH_PERIOD);

    ap_state_t     state, state_n;
    logic [6:0]    led_q;
    logic          match, match_d;
    logic          side_q, side_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic          press_inc, fake_inc;
    logic          press_sig;
    logic [7:0]    lfsr_q;
    logic [7:0]    jitter;

    auto_player_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign match  = (led_q == CUE_PATTERN);
    assign jitter = lfsr_q & {2'b00, JITTER_MASK};

    always_comb begin
        state_n   = state;
        side_n    = side_q;
        qcnt_n    = qcnt;
        rcnt_n    = rcnt;
        pcnt_n    = pcnt;
        press_inc = 1'b0;
        fake_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    side_n  = side;
                    state_n = ARM;
                end
            end
            ARM: begin
                // Only a rising cue qualifies, so a cue held across entry is ignored
                // until it drops and comes back.
                if (mash) begin
                    state_n   = MASH;
                    pcnt_n    = '0;
                    press_inc = 1'b1;
                end else if (match && !match_d) begin
                    state_n = QUAL;
                    qcnt_n  = QW'(1);
                end
            end
            QUAL: begin
                if (!match) begin
                    fake_inc = 1'b1;
                    state_n  = ARM;
                end else if (qcnt == QW'(CUE_MIN)) begin
                    rcnt_n  = RW'(REACT_BASE) + RW'(jitter);
                    state_n = WAIT;
                end else begin
                    qcnt_n = qcnt + QW'(1);
                end
            end
            WAIT: begin
                // Leaving on the last count makes the press start exactly rcnt
                // cycles after WAIT entry; the cue is no longer watched here.
                if (rcnt <= RW'(1)) begin
                    state_n   = PRESS;
                    pcnt_n    = '0;
                    press_inc = 1'b1;
                end else begin
                    rcnt_n = rcnt - RW'(1);
                end
            end
            PRESS: begin
                if (pcnt == PW'(PRESS_CYCLES - 1)) begin
                    state_n = RELEASE;
                end else begin
                    pcnt_n = pcnt + PW'(1);
                end
            end
            RELEASE: begin
                if (!match) begin
                    state_n = ARM;
                end
            end
            MASH: begin
                // Dropping mash is honoured once the high phase is complete.
                if (!mash && pcnt >= PW'(PRESS_CYCLES - 1)) begin
                    state_n = ARM;
                end else if (pcnt == PW'(MASH_PERIOD - 1)) begin
                    pcnt_n    = '0;
                    press_inc = 1'b1;
                end else begin
                    pcnt_n = pcnt + PW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (!enable) begin
            state_n   = IDLE;
            press_inc = 1'b0;
            fake_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            led_q       <= '0;
            match_d     <= 1'b0;
            side_q      <= 1'b0;
            qcnt        <= '0;
            rcnt        <= '0;
            pcnt        <= '0;
            press_count <= '0;
            fake_count  <= '0;
        end else begin
            state   <= state_n;
            led_q   <= Led;
            match_d <= match;
            side_q  <= side_n;
            qcnt    <= qcnt_n;
            rcnt    <= rcnt_n;
            pcnt    <= pcnt_n;
            if (press_inc && press_count != 8'hFF) begin
                press_count <= press_count + 8'd1;
            end
            if (fake_inc && fake_count != 4'hF) begin
                fake_count <= fake_count + 4'd1;
            end
        end
    end

    assign press_sig = (state == PRESS) || (state == MASH && pcnt < PW'(PRESS_CYCLES));
    assign pbl       = press_sig && !side_q;
    assign pbr       = press_sig && side_q;
    assign busy      = (state != IDLE) && (state != ARM);

endmodule

// File: tb/tb_auto_player.sv
// tb/tb_auto_player.sv - self-checking bench for auto_player
module tb_auto_player;

    localparam int CUE_MIN      = 4;
    localparam int REACT_BASE   = 10;
    localparam int PRESS_CYCLES = 3;
    localparam int MASH_PERIOD  = 8;
    localparam int SEED         = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, en_a, en_b, side, mash;
    logic [6:0] led;
    logic       pbl_a, pbr_a, busy_a, pbl_b, pbr_b, busy_b;
    logic [7:0] pc_a, pc_b;
    logic [3:0] fc_a, fc_b;
    int         cyc;
    int         checks   = 0;
    int         failures = 0;

    auto_player #(
        .CUE_MIN(CUE_MIN), .REACT_BASE(REACT_BASE), .JITTER_MASK(6'h00),
        .PRESS_CYCLES(PRESS_CYCLES), .MASH_PERIOD(MASH_PERIOD), .SEED(8'hA5)
    ) u_a (
        .clk(clk), .rst(rst), .enable(en_a), .side(side), .mash(mash), .Led(led),
        .pbl(pbl_a), .pbr(pbr_a), .busy(busy_a), .press_count(pc_a), .fake_count(fc_a)
    );

    auto_player #(
        .CUE_MIN(CUE_MIN), .REACT_BASE(REACT_BASE), .JITTER_MASK(6'h3F),
        .PRESS_CYCLES(PRESS_CYCLES), .MASH_PERIOD(MASH_PERIOD), .SEED(8'hA5)
    ) u_b (
        .clk(clk), .rst(rst), .enable(en_b), .side(side), .mash(mash), .Led(led),
        .pbl(pbl_b), .pbr(pbr_b), .busy(busy_b), .press_count(pc_b), .fake_count(fc_b)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the player's LFSR has stepped exactly this many times.
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic int lfsr_after(input int n);
        int q;
        int fb;
        q = SEED;
        for (int i = 0; i < n; i++) begin
            fb = ((q >> 7) ^ (q >> 5) ^ (q >> 4) ^ (q >> 3)) & 1;
            q  = ((q << 1) | fb) & 255;
        end
        return q;
    endfunction

    // Cue presented before edge 0 is registered, qualified over CUE_MIN edges,
    // then waited on for the reaction delay.
    function automatic int press_start(input int react);
        return 1 + CUE_MIN + react;
    endfunction

    task automatic arm_a(input logic s);
        en_a = 1'b0;
        led  = 7'h00;
        @(negedge clk);
        side = s;
        en_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; en_a = 1'b0; en_b = 1'b0; side = 1'b0; mash = 1'b0; led = 7'h7F;
        repeat (3) @(negedge clk);
        checks++;
        if ({pbl_a, pbr_a, busy_a, pc_a, fc_a} !== 15'd0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=0", {pbl_a, pbr_a, busy_a, pc_a, fc_a});
        end
        checks++;
        if ({pbl_b, pbr_b, busy_b, pc_b, fc_b} !== 15'd0) begin
            failures++;
            $display("FAIL reset_b got=%h exp=0", {pbl_b, pbr_b, busy_b, pc_b, fc_b});
        end
        led = 7'h00;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_press;
        int base;
        int t0;
        logic exp_p;
        arm_a(1'b0);
        base = pc_a;
        t0   = press_start(REACT_BASE);
        led  = 7'h7F;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            exp_p = (k >= t0 && k < t0 + PRESS_CYCLES);
            checks++;
            if (pbl_a !== exp_p) begin
                failures++;
                $display("FAIL single_pbl k=%0d got=%b exp=%b", k, pbl_a, exp_p);
            end
            checks++;
            if (pbr_a !== 1'b0) begin
                failures++;
                $display("FAIL single_pbr k=%0d got=%b exp=0", k, pbr_a);
            end
            if (k == 0 || k == 1) begin
                checks++;
                if (busy_a !== (k == 1)) begin
                    failures++;
                    $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy_a, k == 1);
                end
            end
        end
        checks++;
        if (pc_a !== 8'(base + 1)) begin
            failures++;
            $display("FAIL single_count got=%0d exp=%0d", pc_a, base + 1);
        end
        led = 7'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL single_release got=%b exp=0", busy_a);
        end
    endtask

    task automatic test_fake;
        int fbase;
        int pbase;
        int seen;
        fbase = fc_a;
        pbase = pc_a;
        seen  = 0;
        led   = 7'h7F;
        repeat (2) @(negedge clk);
        led = 7'h00;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (pbl_a) seen++;
        end
        checks++;
        if (fc_a !== 4'(fbase + 1)) begin
            failures++;
            $display("FAIL fake_count got=%0d exp=%0d", fc_a, fbase + 1);
        end
        checks++;
        if (seen != 0 || pc_a !== 8'(pbase)) begin
            failures++;
            $display("FAIL fake_press got=%0d/%0d exp=0/%0d", seen, pc_a, pbase);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL fake_state got=%b exp=0", busy_a);
        end
    endtask

    task automatic test_stale_cue;
        int base;
        int rises;
        logic prev;
        base  = pc_a;
        rises = 0;
        prev  = 1'b0;
        en_a  = 1'b0;
        @(negedge clk);
        led = 7'h7F;
        repeat (3) @(negedge clk);
        en_a = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (pbl_a && !prev) rises++;
            prev = pbl_a;
        end
        checks++;
        if (rises != 0 || pc_a !== 8'(base)) begin
            failures++;
            $display("FAIL stale_ignored got=%0d/%0d exp=0/%0d", rises, pc_a, base);
        end
        // Drop, reassert and hold well past one press: still a single press per cue.
        for (int k = 0; k < 99; k++) begin
            if (k == 0 || k == 72)  led = 7'h00;
            if (k == 2 || k == 74)  led = 7'h7F;
            @(negedge clk);
            if (pbl_a && !prev) rises++;
            prev = pbl_a;
            if (k == 71) begin
                checks++;
                if (rises != 1 || pc_a !== 8'(base + 1)) begin
                    failures++;
                    $display("FAIL stale_first got=%0d/%0d exp=1/%0d", rises, pc_a, base + 1);
                end
            end
        end
        checks++;
        if (rises != 2 || pc_a !== 8'(base + 2)) begin
            failures++;
            $display("FAIL stale_second got=%0d/%0d exp=2/%0d", rises, pc_a, base + 2);
        end
        led = 7'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mash;
        int base;
        logic exp_p;
        arm_a(1'b1);
        base = pc_a;
        mash = 1'b1;
        for (int k = 0; k < 39; k++) begin
            @(negedge clk);
            if (k == 32) mash = 1'b0;
            exp_p = (k <= 34) && ((k % MASH_PERIOD) < PRESS_CYCLES);
            checks++;
            if (pbr_a !== exp_p || pbl_a !== 1'b0) begin
                failures++;
                $display("FAIL mash_pattern k=%0d got=%b%b exp=%b0", k, pbr_a, pbl_a, exp_p);
            end
        end
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL mash_exit got=%b exp=0", busy_a);
        end
        checks++;
        if (pc_a !== 8'(base + 5)) begin
            failures++;
            $display("FAIL mash_count got=%0d exp=%0d", pc_a, base + 5);
        end
    endtask

    task automatic test_enable_drop;
        int base;
        arm_a(1'b0);
        base = pc_a;
        led  = 7'h7F;
        repeat (press_start(REACT_BASE) + 1) @(negedge clk);
        checks++;
        if (pbl_a !== 1'b1) begin
            failures++;
            $display("FAIL endrop_pressing got=%b exp=1", pbl_a);
        end
        en_a = 1'b0;
        @(negedge clk);
        checks++;
        if (pbl_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL endrop_idle got=%b%b exp=00", pbl_a, busy_a);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (pc_a !== 8'(base + 1)) begin
            failures++;
            $display("FAIL endrop_count got=%0d exp=%0d", pc_a, base + 1);
        end
        led = 7'h00;
    endtask

    task automatic test_saturation;
        int expect_pc;
        arm_a(1'b0);
        expect_pc = pc_a + 300;
        if (expect_pc > 255) expect_pc = 255;
        for (int n = 0; n < 300; n++) begin
            led = 7'h7F;
            repeat (CUE_MIN + 2) @(negedge clk);
            led = 7'h00;
            repeat (18) @(negedge clk);
        end
        checks++;
        if (pc_a !== 8'(expect_pc)) begin
            failures++;
            $display("FAIL saturate got=%0d exp=%0d", pc_a, expect_pc);
        end
    endtask

    task automatic test_reset_mid_press;
        led = 7'h7F;
        repeat (press_start(REACT_BASE) + 1) @(negedge clk);
        checks++;
        if (pbl_a !== 1'b1) begin
            failures++;
            $display("FAIL rstpress_pressing got=%b exp=1", pbl_a);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pbl_a !== 1'b0 || busy_a !== 1'b0 || pc_a !== 8'd0) begin
            failures++;
            $display("FAIL rstpress_cleared got=%b%b/%0d exp=00/0", pbl_a, busy_a, pc_a);
        end
        led = 7'h00;
    endtask

    task automatic test_jitter;
        int c0;
        int r_exp;
        int delay;
        int seen;
        rst = 1'b0; en_a = 1'b0; en_b = 1'b0; side = 1'b0; mash = 1'b0; led = 7'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        en_b = 1'b1;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            c0    = cyc;
            r_exp = REACT_BASE + (lfsr_after(c0 + CUE_MIN + 1) & 8'h3F);
            seen  = 0;
            delay = -1;
            led   = 7'h7F;
            for (int k = 0; k < 120; k++) begin
                @(negedge clk);
                if (k == CUE_MIN + 1) led = 7'h00;
                if (pbl_b && seen == 0) begin
                    seen  = 1;
                    delay = cyc - (c0 + CUE_MIN + 2);
                end
            end
            checks++;
            if (delay != r_exp) begin
                failures++;
                $display("FAIL jitter_delay cue=%0d got=%0d exp=%0d", n, delay, r_exp);
            end
            checks++;
            if (delay < REACT_BASE || delay > REACT_BASE + 63) begin
                failures++;
                $display("FAIL jitter_range cue=%0d got=%0d exp=%0d..%0d",
                         n, delay, REACT_BASE, REACT_BASE + 63);
            end
        end
        checks++;
        if (pc_b !== 8'd8) begin
            failures++;
            $display("FAIL jitter_count got=%0d exp=8", pc_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_fake();
        test_stale_cue();
        test_mash();
        test_enable_drop();
        test_saturation();
        test_reset_mid_press();
        test_jitter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
